mem_port_arbiter: RTL and testbench

- Shares the single-ported unified memory between instruction fetch (IF stage, PC-driven) and data access (MEM stage, EX/MEM buffer-driven).
- Sequences one memory transaction at a time. Returns read data or a write acknowledge to the winning requester.
- Exposes a stall indication that the hazard detection logic uses to hold the PC and the IF/ID buffer.

---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/arb_starve_ctr.sv | 29 ++
 rtl/mem_port_arbiter.sv | 138 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared definitions for the memory port arbiter: FSM encoding and the
// requester IDs stored in the registered owner flag.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } arb_state_t;

  localparam logic REQ_IF = 1'b0;
  localparam logic REQ_D  = 1'b1;

endpackage

// File: rtl/arb_starve_ctr.sv
// Saturating count of consecutive denied fetch cycles; hit flags that the
// threshold has been reached so fetch can win the next arbitration.
module arb_starve_ctr #(
  parameter int MAX = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam int CNT_W = $clog2(MAX + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != CNT_W'(MAX))) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  assign hit = (cnt >= CNT_W'(MAX));

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Define MEM_ARB_STARVE_GUARD_EN to promote fetch after STARVE_MAX denied cycles.
//
// state | meaning
// IDLE  | arbitrating, grants driven combinationally
// ISSUE | m_en high for one cycle
// WAIT  | counting MEM_LAT cycles down to read-data capture
// RESP  | rvalid/ack pulse, arbitrates like IDLE in the same cycle
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_stall,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_gnt,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_en,
  output logic              m_we,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic [DATA_W-1:0] m_rdata,
  output logic              busy
);

  localparam int LAT_W = $clog2(MEM_LAT + 1);

  arb_state_t       state, state_nxt;
  logic [LAT_W-1:0] lat_cnt;
  logic             owner_q;
  logic             we_q;
  logic             arb_ok;
  logic             fetch_pri;
  logic             lat_done;

`ifdef MEM_ARB_STARVE_GUARD_EN
  arb_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve_ctr (
    .clk   (clk),
    .reset (reset),
    .inc   (if_req & ~if_gnt),
    .clr   (~if_req | if_gnt),
    .hit   (fetch_pri)
  );
`else
  // Without the guard the threshold has no effect; data always wins.
  logic unused_starve_max;
  assign unused_starve_max = ^STARVE_MAX;
  assign fetch_pri         = 1'b0;
`endif

  // Grants are held off while reset is asserted so no transfer is taken then.
  assign arb_ok   = ((state == IDLE) || (state == RESP)) && !reset;
  assign d_gnt    = arb_ok & d_req & ~(fetch_pri & if_req);
  assign if_gnt   = arb_ok & if_req & (~d_req | fetch_pri);
  assign if_stall = if_req & ~if_gnt & ~reset;

  assign lat_done = (lat_cnt == LAT_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (d_gnt || if_gnt) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (lat_done) state_nxt = RESP;
      RESP:    state_nxt = (d_gnt || if_gnt) ? ISSUE : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_cnt  <= '0;
      owner_q  <= REQ_IF;
      we_q     <= 1'b0;
      m_addr   <= '0;
      m_wdata  <= '0;
      if_rdata <= '0;
      d_rdata  <= '0;
    end else begin
      if (d_gnt) begin
        owner_q <= REQ_D;
        we_q    <= d_we;
        m_addr  <= d_addr;
        m_wdata <= d_wdata;
      end else if (if_gnt) begin
        owner_q <= REQ_IF;
        we_q    <= 1'b0;
        m_addr  <= if_addr;
      end

      if (state == ISSUE) begin
        lat_cnt <= LAT_W'(MEM_LAT);
      end else if (state == WAIT) begin
        lat_cnt <= lat_cnt - LAT_W'(1);
      end

      // Read data is captured on the last WAIT cycle; writes leave d_rdata alone.
      if ((state == WAIT) && lat_done) begin
        if (owner_q == REQ_IF) begin
          if_rdata <= m_rdata;
        end else if (!we_q) begin
          d_rdata <= m_rdata;
        end
      end
    end
  end

  assign m_en      = (state == ISSUE);
  assign m_we      = m_en & we_q;
  assign busy      = (state == ISSUE) || (state == WAIT);
  assign if_rvalid = (state == RESP) && (owner_q == REQ_IF);
  assign d_ack     = (state == RESP) && (owner_q == REQ_D);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: vector table plus corner-case
// sequences, with a read-data scoreboard and a latency-accurate memory model.
module tb_mem_port_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic        if_req, d_req, d_we;
  logic [15:0] if_addr, d_addr, d_wdata, m_rdata1;
  logic        if_gnt, if_rvalid, if_stall, d_gnt, d_ack, m_en, m_we, busy;
  logic [15:0] if_rdata, d_rdata, m_addr, m_wdata;

  logic        if_req3, d_req3;
  logic [15:0] m_rdata3;
  logic        if_gnt3, if_rvalid3, if_stall3, d_gnt3, d_ack3, m_en3, m_we3, busy3;
  logic [15:0] if_rdata3, d_rdata3, m_addr3, m_wdata3;

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(1), .STARVE_MAX(4)) u_dut1 (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
    .if_rdata(if_rdata), .if_stall(if_stall),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_ack(d_ack), .d_rdata(d_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_rdata(m_rdata1), .busy(busy)
  );

  mem_port_arbiter #(.ADDR_W(16), .DATA_W(16), .MEM_LAT(3), .STARVE_MAX(4)) u_dut3 (
    .clk(clk), .reset(reset),
    .if_req(if_req3), .if_addr(if_addr), .if_gnt(if_gnt3), .if_rvalid(if_rvalid3),
    .if_rdata(if_rdata3), .if_stall(if_stall3),
    .d_req(d_req3), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt3), .d_ack(d_ack3), .d_rdata(d_rdata3),
    .m_en(m_en3), .m_we(m_we3), .m_addr(m_addr3), .m_wdata(m_wdata3),
    .m_rdata(m_rdata3), .busy(busy3)
  );

  // Memory: data is valid only in the one cycle MEM_LAT after m_en, else 0xDEAD.
  logic [15:0] mem [0:255];
  logic [15:0] p3 [0:2];
  always @(posedge clk) begin
    if (m_en && m_we) mem[m_addr[7:0]] <= m_wdata;
    m_rdata1 <= (m_en && !m_we) ? mem[m_addr[7:0]] : 16'hDEAD;
    p3[0]    <= (m_en3 && !m_we3) ? mem[m_addr3[7:0]] : 16'hDEAD;
    p3[1]    <= p3[0];
    p3[2]    <= p3[1];
  end
  assign m_rdata3 = p3[2];

  typedef struct {
    logic        fetch;
    logic        we;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp;
  } vec_t;

  localparam int NV = 11;
  vec_t        vecs [NV];
  logic [15:0] if_q [$];
  logic [15:0] d_q [$];
  logic [15:0] last_rd;
  int          checks = 0;
  int          errors = 0;
  int          n, lat, first_if;
  logic        drop_if;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Scoreboard side: every response pulse must match a queued expectation.
  task automatic monitor();
    if (!reset) begin
      if (if_rvalid) begin
        if (if_q.size() == 0) chk("sb_if_unexpected", 32'd1, 32'd0);
        else chk("sb_if_rdata", if_rdata, if_q.pop_front());
      end
      if (d_ack) begin
        if (d_q.size() == 0) chk("sb_d_unexpected", 32'd1, 32'd0);
        else chk("sb_d_rdata", d_rdata, d_q.pop_front());
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    monitor();
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_if_gnt"}, if_gnt, 0);     chk({tag, "_if_rvalid"}, if_rvalid, 0);
    chk({tag, "_if_rdata"}, if_rdata, 0); chk({tag, "_if_stall"}, if_stall, 0);
    chk({tag, "_d_gnt"}, d_gnt, 0);       chk({tag, "_d_ack"}, d_ack, 0);
    chk({tag, "_d_rdata"}, d_rdata, 0);   chk({tag, "_m_en"}, m_en, 0);
    chk({tag, "_m_we"}, m_we, 0);         chk({tag, "_m_addr"}, m_addr, 0);
    chk({tag, "_m_wdata"}, m_wdata, 0);   chk({tag, "_busy"}, busy, 0);
  endtask

  task automatic fetch_seq(input string tag);
    step(); if_req = 1'b1; if_addr = 16'h0004; #1;
    chk({tag, "_c0_if_gnt"}, if_gnt, 1); chk({tag, "_c0_if_stall"}, if_stall, 0);
    if_q.push_back(16'h1234);
    step(); if_req = 1'b0; #1;
    chk({tag, "_c1_m_en"}, m_en, 1);   chk({tag, "_c1_m_we"}, m_we, 0);
    chk({tag, "_c1_m_addr"}, m_addr, 16'h0004); chk({tag, "_c1_busy"}, busy, 1);
    step(); #1;
    chk({tag, "_c2_m_en"}, m_en, 0);   chk({tag, "_c2_rvalid"}, if_rvalid, 0);
    step(); #1;
    chk({tag, "_c3_rvalid"}, if_rvalid, 1); chk({tag, "_c3_rdata"}, if_rdata, 16'h1234);
    chk({tag, "_c3_busy"}, busy, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{1'b0, 1'b1, 16'h0004, 16'h1234, 16'h0000};
    vecs[1]  = '{1'b0, 1'b1, 16'h0006, 16'h7777, 16'h0000};
    vecs[2]  = '{1'b0, 1'b1, 16'h0010, 16'hBEEF, 16'h0000};
    vecs[3]  = '{1'b0, 1'b1, 16'h0020, 16'h00FF, 16'h0000};
    vecs[4]  = '{1'b1, 1'b0, 16'h0004, 16'h0000, 16'h1234};
    vecs[5]  = '{1'b0, 1'b0, 16'h0010, 16'h0000, 16'hBEEF};
    vecs[6]  = '{1'b1, 1'b0, 16'h0006, 16'h0000, 16'h7777};
    vecs[7]  = '{1'b0, 1'b0, 16'h0020, 16'h0000, 16'h00FF};
    vecs[8]  = '{1'b0, 1'b1, 16'h0030, 16'hA5A5, 16'h0000};
    vecs[9]  = '{1'b1, 1'b0, 16'h0030, 16'h0000, 16'hA5A5};
    vecs[10] = '{1'b0, 1'b0, 16'h0030, 16'h0000, 16'hA5A5};

    reset = 1'b1; if_req = 0; d_req = 0; d_we = 0; if_req3 = 0; d_req3 = 0;
    if_addr = 0; d_addr = 0; d_wdata = 0; last_rd = 16'h0000;
    repeat (2) @(posedge clk);
    #2;
    chk_zero("reset");
    reset = 1'b0;

    for (int i = 0; i < NV; i++) begin
      step();
      if (vecs[i].fetch) begin
        if_req = 1'b1; if_addr = vecs[i].addr;
      end else begin
        d_req = 1'b1; d_we = vecs[i].we; d_addr = vecs[i].addr; d_wdata = vecs[i].wdata;
      end
      #1;
      n = 0;
      while (!(vecs[i].fetch ? if_gnt : d_gnt) && n < 20) begin step(); #1; n++; end
      chk($sformatf("v%0d_gnt_delay", i), n, 0);
      if (vecs[i].fetch) if_q.push_back(vecs[i].exp);
      else if (vecs[i].we) d_q.push_back(last_rd);
      else begin d_q.push_back(vecs[i].exp); last_rd = vecs[i].exp; end
      step(); if_req = 1'b0; d_req = 1'b0; d_we = 1'b0; #1;
      chk($sformatf("v%0d_m_en", i), m_en, 1);
      chk($sformatf("v%0d_m_we", i), m_we, vecs[i].we);
      chk($sformatf("v%0d_m_addr", i), m_addr, vecs[i].addr);
      if (vecs[i].we) chk($sformatf("v%0d_m_wdata", i), m_wdata, vecs[i].wdata);
      lat = 1;
      while (!(vecs[i].fetch ? if_rvalid : d_ack) && lat < 20) begin step(); #1; lat++; end
      chk($sformatf("v%0d_resp_cycle", i), lat, 3);
    end

    fetch_seq("fetch");

    // Simultaneous requests: data write wins, fetch granted in the RESP cycle.
    step();
    if_req = 1'b1; if_addr = 16'h0006;
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0010; d_wdata = 16'hBEEF; #1;
    chk("sim_c0_d_gnt", d_gnt, 1); chk("sim_c0_if_gnt", if_gnt, 0); chk("sim_c0_stall", if_stall, 1);
    d_q.push_back(last_rd);
    step(); d_req = 1'b0; d_we = 1'b0; #1;
    chk("sim_c1_m_we", m_we, 1); chk("sim_c1_m_wdata", m_wdata, 16'hBEEF);
    chk("sim_c1_m_addr", m_addr, 16'h0010); chk("sim_c1_if_gnt", if_gnt, 0);
    step(); #1;
    step(); #1;
    chk("sim_c3_d_ack", d_ack, 1); chk("sim_c3_d_rdata", d_rdata, last_rd); chk("sim_c3_if_gnt", if_gnt, 1);
    if_q.push_back(16'h7777);
    step(); if_req = 1'b0; #1;
    chk("sim_c4_m_addr", m_addr, 16'h0006); chk("sim_c4_m_we", m_we, 0);
    step(); #1;
    step(); #1;
    chk("sim_c6_if_rvalid", if_rvalid, 1);

    // Back-to-back data reads.
    step(); d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010; #1;
    chk("b2b_c0_d_gnt", d_gnt, 1);
    d_q.push_back(16'hBEEF);
    step(); d_addr = 16'h0020; #1;
    chk("b2b_c1_d_gnt", d_gnt, 0);
    step(); #1;
    step(); #1;
    chk("b2b_c3_d_gnt", d_gnt, 1); chk("b2b_c3_d_ack", d_ack, 1);
    d_q.push_back(16'h00FF);
    step(); d_req = 1'b0; #1;
    step(); #1;
    step(); #1;
    chk("b2b_c6_d_ack", d_ack, 1); chk("b2b_c6_d_rdata", d_rdata, 16'h00FF);
    last_rd = 16'h00FF;

    // Data held continuously against a pending fetch.
    step(); d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0010; if_req = 1'b1; if_addr = 16'h0004; #1;
    first_if = -1; drop_if = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) begin step(); if (drop_if) if_req = 1'b0; #1; end
      if (d_gnt) d_q.push_back(16'hBEEF);
      if (if_gnt && first_if < 0) begin first_if = c; if_q.push_back(16'h1234); drop_if = 1'b1; end
    end
    last_rd = 16'hBEEF;
`ifdef MEM_ARB_STARVE_GUARD_EN
    chk("starve_if_gnt_cycle", first_if, 6);
    step(); d_req = 1'b0; #1;
`else
    chk("starve_if_gnt_cycle", first_if, -1);
    step(); d_req = 1'b0; #1;
    n = 0;
    while (!if_gnt && n < 20) begin step(); #1; n++; end
    chk("starve_release_gnt", (n < 20), 1);
    if_q.push_back(16'h1234);
    step(); if_req = 1'b0;
`endif
    repeat (8) step();

    // Reset in cycle 2 of a read drops the transaction.
    step(); d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0020; #1;
    chk("rst_c0_d_gnt", d_gnt, 1);
    step(); d_req = 1'b0;
    step(); #1;
    reset = 1'b1; #1;
    chk_zero("rst_mid");
    step(); step();
    reset = 1'b0;
    repeat (4) step();
    chk("rst_after_busy", busy, 0);
    last_rd = 16'h0000;
    fetch_seq("post_rst");

    // MEM_LAT=3 data read on the second instance.
    step(); d_req3 = 1'b1; d_we = 1'b0; d_addr = 16'h0020; #1;
    chk("lat3_c0_d_gnt", d_gnt3, 1);
    for (int c = 1; c <= 5; c++) begin
      step(); if (c == 1) d_req3 = 1'b0; #1;
      chk($sformatf("lat3_c%0d_busy", c), busy3, (c <= 4));
      chk($sformatf("lat3_c%0d_d_ack", c), d_ack3, (c == 5));
      if (c == 1) chk("lat3_c1_m_en", m_en3, 1);
    end
    chk("lat3_c5_d_rdata", d_rdata3, 16'h00FF);

    repeat (4) step();
    chk("sb_if_drained", if_q.size(), 0);
    chk("sb_d_drained", d_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
